// File: rtl/mcbsp_tx_buffer.sv
// Frame-oriented transmit FIFO feeding the McBSP master: buffers words, starts a
// frame once enough are stored, and pops one word per master update strobe.
module mcbsp_tx_buffer #(
  parameter int          ADDR_W        = 9,
  parameter logic [31:0] UNDERRUN_WORD = 32'h0000_0000
) (
  input  logic              mcbsp_clk_in,
  input  logic              mcbsp_rst_n_in,
  input  logic [8:0]        mcbsp_reg_number,
  input  logic [6:0]        mcbsp_reg_length,
  input  logic              tx_enable,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  input  logic              mcbsp_update_in,
  output logic              mcbsp_master_en,
  output logic [31:0]       mcbsp_data_out,
  output logic [ADDR_W:0]   fifo_level,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overflow,
  output logic              underflow,
  output logic              busy,
  output logic [15:0]       frame_count
);

  localparam int               DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0]  FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  LEVEL_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE   = 1;

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              pop_d1;
  logic              pop_empty_d1;
  logic              do_write;
  logic              do_pop;

  state_t            state;
  state_t            state_next;
  logic [8:0]        num_q;
  logic [6:0]        len_q;
  logic [8:0]        wcnt;
  logic [8:0]        wcnt_inc;
  logic [8:0]        gcnt;
  logic [8:0]        gap_last;

  assign fifo_full  = (fifo_level == FULL_LEVEL);
  assign fifo_empty = (fifo_level == '0);
  assign do_write   = wr_en && !fifo_full && !flush;
  assign do_pop     = mcbsp_update_in && !fifo_empty && !flush;

  // Storage has no reset so it maps onto block RAM; the read port is registered.
  always_ff @(negedge mcbsp_clk_in) begin
    if (do_write) begin
      mem[wr_ptr] <= wr_data;
    end
    if (mcbsp_update_in) begin
      rd_q <= mem[rd_ptr];
    end
  end

  always_ff @(negedge mcbsp_clk_in or negedge mcbsp_rst_n_in) begin
    if (!mcbsp_rst_n_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
      end else begin
        if (do_write) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        case ({do_write, do_pop})
          2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
          2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
          default: fifo_level <= fifo_level;
        endcase
      end
      if (wr_en && fifo_full && !flush) begin
        overflow <= 1'b1;
      end
      if (mcbsp_update_in && fifo_empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // Second pipeline stage of a pop: the word lands two clocks after the master's strobe.
  always_ff @(negedge mcbsp_clk_in or negedge mcbsp_rst_n_in) begin
    if (!mcbsp_rst_n_in) begin
      pop_d1         <= 1'b0;
      pop_empty_d1   <= 1'b0;
      mcbsp_data_out <= '0;
    end else begin
      pop_d1       <= mcbsp_update_in;
      pop_empty_d1 <= fifo_empty;
      if (pop_d1) begin
        mcbsp_data_out <= pop_empty_d1 ? UNDERRUN_WORD : rd_q;
      end
    end
  end

  assign wcnt_inc = wcnt + 9'd1;
  assign gap_last = {1'b0, len_q, 1'b0} + 9'd3;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (tx_enable && (mcbsp_reg_number != 9'd0) &&
            (int'(fifo_level) >= int'(mcbsp_reg_number))) begin
          state_next = START;
        end
      end
      START: state_next = SEND;
      SEND: begin
        if (mcbsp_update_in && (wcnt_inc == num_q)) begin
          state_next = GAP;
        end
      end
      GAP: begin
        if (gcnt == gap_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  // Frame geometry is captured at frame start so mid-frame register writes are ignored.
  always_ff @(negedge mcbsp_clk_in or negedge mcbsp_rst_n_in) begin
    if (!mcbsp_rst_n_in) begin
      state       <= IDLE;
      num_q       <= '0;
      len_q       <= '0;
      wcnt        <= '0;
      gcnt        <= '0;
      frame_count <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && (state_next == START)) begin
        num_q <= mcbsp_reg_number;
        len_q <= mcbsp_reg_length;
      end
      if (state == START) begin
        wcnt <= '0;
      end else if ((state == SEND) && mcbsp_update_in) begin
        wcnt <= wcnt_inc;
      end
      if (state == GAP) begin
        gcnt <= gcnt + 9'd1;
      end else begin
        gcnt <= '0;
      end
      if ((state == GAP) && (gcnt == gap_last) && !flush) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  assign mcbsp_master_en = (state == START);
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_mcbsp_tx_buffer.sv
// Scoreboard bench for mcbsp_tx_buffer: directed frames, underrun, overflow,
// flush, asynchronous reset and back-to-back framing.
module tb_mcbsp_tx_buffer;

  logic        mcbsp_clk_in = 1'b0;
  logic        mcbsp_rst_n_in = 1'b0;
  logic [8:0]  mcbsp_reg_number = '0;
  logic [6:0]  mcbsp_reg_length = '0;
  logic        tx_enable = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        mcbsp_update_in = 1'b0;
  logic        mcbsp_master_en;
  logic [31:0] mcbsp_data_out;
  logic [9:0]  fifo_level;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;
  logic        underflow;
  logic        busy;
  logic [15:0] frame_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  pend;

  mcbsp_tx_buffer #(.ADDR_W(9), .UNDERRUN_WORD(32'h0000_0000)) dut (
    .mcbsp_clk_in     (mcbsp_clk_in),
    .mcbsp_rst_n_in   (mcbsp_rst_n_in),
    .mcbsp_reg_number (mcbsp_reg_number),
    .mcbsp_reg_length (mcbsp_reg_length),
    .tx_enable        (tx_enable),
    .flush            (flush),
    .wr_en            (wr_en),
    .wr_data          (wr_data),
    .mcbsp_update_in  (mcbsp_update_in),
    .mcbsp_master_en  (mcbsp_master_en),
    .mcbsp_data_out   (mcbsp_data_out),
    .fifo_level       (fifo_level),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .overflow         (overflow),
    .underflow        (underflow),
    .busy             (busy),
    .frame_count      (frame_count)
  );

  always #5 mcbsp_clk_in = ~mcbsp_clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: a strobe seen on a falling edge yields data after the following falling edge.
  always @(negedge mcbsp_clk_in or negedge mcbsp_rst_n_in) begin
    if (!mcbsp_rst_n_in) pend <= 2'b00;
    else                 pend <= {pend[0], mcbsp_update_in};
  end

  always @(posedge mcbsp_clk_in) begin
    if (pend[1]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL data_out unexpected pop: got %h expected none", mcbsp_data_out);
      end else begin
        checkOutput("data_out", mcbsp_data_out, exp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] data, input logic upd);
    wr_en = we;
    wr_data = data;
    mcbsp_update_in = upd;
    @(posedge mcbsp_clk_in);
    wr_en = 1'b0;
    mcbsp_update_in = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] w);
    applyStimulus(1'b1, w, 1'b0);
  endtask

  task automatic pop_word(input logic [31:0] expected, input int spacing);
    exp_q.push_back(expected);
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (spacing) @(posedge mcbsp_clk_in);
  endtask

  task automatic wait_pulse(input string name);
    int n = 0;
    while (!mcbsp_master_en && n < 50) begin
      @(posedge mcbsp_clk_in);
      n++;
    end
    checkOutput({name, " master_en rise"}, 32'(mcbsp_master_en), 32'd1);
    if (mcbsp_master_en) begin
      @(posedge mcbsp_clk_in);
      checkOutput({name, " master_en width"}, 32'(mcbsp_master_en), 32'd0);
    end
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (busy && n < 400) begin
      @(posedge mcbsp_clk_in);
      n++;
    end
    checkOutput({name, " frame end"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, " master_en"},   32'(mcbsp_master_en), 32'd0);
    checkOutput({tag, " data_out"},    mcbsp_data_out,       32'd0);
    checkOutput({tag, " level"},       32'(fifo_level),      32'd0);
    checkOutput({tag, " full"},        32'(fifo_full),       32'd0);
    checkOutput({tag, " empty"},       32'(fifo_empty),      32'd1);
    checkOutput({tag, " overflow"},    32'(overflow),        32'd0);
    checkOutput({tag, " underflow"},   32'(underflow),       32'd0);
    checkOutput({tag, " busy"},        32'(busy),            32'd0);
    checkOutput({tag, " frame_count"}, 32'(frame_count),     32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int seen;

    repeat (3) @(posedge mcbsp_clk_in);
    check_reset_values("reset");
    mcbsp_rst_n_in = 1'b1;
    @(posedge mcbsp_clk_in);

    $display("[TB] basic frame of four words");
    mcbsp_reg_number = 9'd4;
    mcbsp_reg_length = 7'd32;
    tx_enable = 1'b1;
    write_word(32'h1111_1111);
    write_word(32'h2222_2222);
    write_word(32'h3333_3333);
    write_word(32'h4444_4444);
    wait_pulse("frame1");
    pop_word(32'h1111_1111, 2);
    pop_word(32'h2222_2222, 2);
    pop_word(32'h3333_3333, 2);
    pop_word(32'h4444_4444, 0);
    wait_idle("frame1", n);
    checkOutput("frame1 gap cycles", 32'(n), 32'd68);
    checkOutput("frame1 frame_count", 32'(frame_count), 32'd1);
    checkOutput("frame1 level", 32'(fifo_level), 32'd0);

    $display("[TB] short fill holds off start");
    mcbsp_reg_number = 9'd5;
    write_word(32'hA000_0000);
    write_word(32'hA000_0001);
    write_word(32'hA000_0002);
    write_word(32'hA000_0003);
    seen = 0;
    repeat (5) begin
      @(posedge mcbsp_clk_in);
      seen += int'(mcbsp_master_en) + int'(busy);
    end
    checkOutput("short fill no start", 32'(seen), 32'd0);
    write_word(32'hA000_0004);
    checkOutput("fifth write same cycle", 32'(mcbsp_master_en), 32'd0);
    @(posedge mcbsp_clk_in);
    checkOutput("fifth write starts", 32'(mcbsp_master_en), 32'd1);
    @(posedge mcbsp_clk_in);
    checkOutput("fifth write pulse width", 32'(mcbsp_master_en), 32'd0);
    pop_word(32'hA000_0000, 2);
    pop_word(32'hA000_0001, 2);
    pop_word(32'hA000_0002, 2);
    pop_word(32'hA000_0003, 2);
    pop_word(32'hA000_0004, 0);
    wait_idle("frame2", n);
    checkOutput("frame2 frame_count", 32'(frame_count), 32'd2);

    $display("[TB] underrun");
    tx_enable = 1'b0;
    checkOutput("underflow before", 32'(underflow), 32'd0);
    write_word(32'hB000_0000);
    write_word(32'hB000_0001);
    write_word(32'hB000_0002);
    write_word(32'hB000_0003);
    pop_word(32'hB000_0000, 1);
    pop_word(32'hB000_0001, 1);
    pop_word(32'hB000_0002, 1);
    pop_word(32'hB000_0003, 1);
    pop_word(32'h0000_0000, 1);
    pop_word(32'h0000_0000, 3);
    checkOutput("underrun underflow", 32'(underflow), 32'd1);
    checkOutput("underrun level", 32'(fifo_level), 32'd0);
    checkOutput("underrun empty", 32'(fifo_empty), 32'd1);

    $display("[TB] fill and overflow");
    for (int i = 0; i < 511; i++) write_word({16'hC0DE, 16'(i)});
    checkOutput("fill 511 level", 32'(fifo_level), 32'd511);
    checkOutput("fill 511 full", 32'(fifo_full), 32'd0);
    write_word({16'hC0DE, 16'd511});
    checkOutput("fill 512 level", 32'(fifo_level), 32'd512);
    checkOutput("fill 512 full", 32'(fifo_full), 32'd1);
    checkOutput("fill 512 overflow", 32'(overflow), 32'd0);
    write_word(32'hDEAD_BEEF);
    checkOutput("overflow set", 32'(overflow), 32'd1);
    checkOutput("overflow level", 32'(fifo_level), 32'd512);
    for (int i = 0; i < 512; i++) pop_word({16'hC0DE, 16'(i)}, 0);
    pop_word(32'h0000_0000, 3);
    checkOutput("drain empty", 32'(fifo_empty), 32'd1);

    $display("[TB] flush mid frame");
    mcbsp_reg_number = 9'd4;
    mcbsp_reg_length = 7'd8;
    tx_enable = 1'b1;
    write_word(32'hD000_0000);
    write_word(32'hD000_0001);
    write_word(32'hD000_0002);
    write_word(32'hD000_0003);
    wait_pulse("flush frame");
    pop_word(32'hD000_0000, 2);
    pop_word(32'hD000_0001, 2);
    checkOutput("flush pre busy", 32'(busy), 32'd1);
    flush = 1'b1;
    write_word(32'hBAD0_0001);
    flush = 1'b0;
    checkOutput("flush level", 32'(fifo_level), 32'd0);
    checkOutput("flush empty", 32'(fifo_empty), 32'd1);
    checkOutput("flush busy", 32'(busy), 32'd0);
    checkOutput("flush master_en", 32'(mcbsp_master_en), 32'd0);
    checkOutput("flush keeps overflow", 32'(overflow), 32'd1);
    checkOutput("flush keeps underflow", 32'(underflow), 32'd1);
    checkOutput("flush keeps frame_count", 32'(frame_count), 32'd2);
    repeat (3) @(posedge mcbsp_clk_in);
    checkOutput("flush stays idle", 32'(busy), 32'd0);

    $display("[TB] reset during gap");
    write_word(32'hE000_0000);
    write_word(32'hE000_0001);
    write_word(32'hE000_0002);
    write_word(32'hE000_0003);
    wait_pulse("reset frame");
    pop_word(32'hE000_0000, 1);
    pop_word(32'hE000_0001, 1);
    pop_word(32'hE000_0002, 1);
    pop_word(32'hE000_0003, 0);
    repeat (5) @(posedge mcbsp_clk_in);
    checkOutput("in gap busy", 32'(busy), 32'd1);
    mcbsp_rst_n_in = 1'b0;
    #1;
    check_reset_values("async reset");
    @(posedge mcbsp_clk_in);
    mcbsp_rst_n_in = 1'b1;
    @(posedge mcbsp_clk_in);

    $display("[TB] back-to-back frames");
    tx_enable = 1'b0;
    mcbsp_reg_number = 9'd4;
    mcbsp_reg_length = 7'd4;
    for (int i = 0; i < 8; i++) write_word(32'hF000_0000 + 32'(i));
    tx_enable = 1'b1;
    wait_pulse("b2b first");
    pop_word(32'hF000_0000, 1);
    pop_word(32'hF000_0001, 1);
    pop_word(32'hF000_0002, 1);
    pop_word(32'hF000_0003, 0);
    wait_idle("b2b first", n);
    checkOutput("b2b first gap cycles", 32'(n), 32'd12);
    n = 0;
    while (!busy && n < 20) begin
      n++;
      @(posedge mcbsp_clk_in);
    end
    checkOutput("b2b idle cycles", 32'(n), 32'd1);
    checkOutput("b2b second master_en", 32'(mcbsp_master_en), 32'd1);
    @(posedge mcbsp_clk_in);
    checkOutput("b2b second width", 32'(mcbsp_master_en), 32'd0);
    pop_word(32'hF000_0004, 1);
    pop_word(32'hF000_0005, 1);
    pop_word(32'hF000_0006, 1);
    pop_word(32'hF000_0007, 0);
    wait_idle("b2b second", n);
    checkOutput("b2b frame_count", 32'(frame_count), 32'd2);
    checkOutput("b2b level", 32'(fifo_level), 32'd0);

    repeat (4) @(posedge mcbsp_clk_in);
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcbsp_tx_buffer.md
Name: mcbsp_tx_buffer

Overview:
- Upstream feeder for the McBSP master transmitter.
- Buffers 32-bit words from the Link16 receive path in a block-RAM FIFO.
- Once a full frame of mcbsp_reg_number words is stored, it issues a one-cycle master enable pulse.
- During the frame it supplies one word per update strobe from the master, then holds off until the master's trailing word periods have finished.

Parameters:
- ADDR_W, 9, FIFO address width; depth = 2^ADDR_W words (512).
- UNDERRUN_WORD, 32'h0000_0000, value driven on mcbsp_data_out when a pop hits an empty FIFO.

Ports:
- mcbsp_clk_in  in  1  transmitter clock (20 MHz); all logic on its negedge, the same edge the master uses.
- mcbsp_rst_n_in  in  1  asynchronous active-low reset.
- mcbsp_reg_number  in  9  words per frame.
- mcbsp_reg_length  in  7  bits per word period.
- tx_enable  in  1  allows frame starts.
- flush  in  1  synchronous FIFO clear.
- wr_en  in  1  write strobe.
- wr_data  in  32  word to buffer.
- mcbsp_update_in  in  1  pop strobe from the master (one cycle).
- mcbsp_master_en  out  1  frame start pulse to the master.
- mcbsp_data_out  out  32  word to the master's mcbsp_data_in.
- fifo_level  out  ADDR_W+1  words stored.
- fifo_full  out  1  level == 2^ADDR_W.
- fifo_empty  out  1  level == 0.
- overflow  out  1  sticky; write while full.
- underflow  out  1  sticky; pop while empty.
- busy  out  1  state != IDLE.
- frame_count  out  16  completed frames, wraps.

Behaviour:
- Reset (async, low) values:
  - master_en = 0, data_out = 0, level = 0, pointers = 0.
  - full = 0, empty = 1, overflow = 0, underflow = 0, busy = 0, frame_count = 0.
  - State = IDLE.
- FIFO:
  - Simple dual-port RAM with registered read.
  - A write with wr_en && !full stores the word and increments wr_ptr.
  - A write while full drops the word and sets overflow.
  - Simultaneous write and pop leaves the level unchanged.
  - Pointers wrap modulo 2^ADDR_W.
- Pop:
  - Triggered by mcbsp_update_in.
  - mcbsp_data_out holds the popped word exactly 2 clocks after the update edge and stays stable until the next pop.
  - Timing rationale: the master strobes update at bit count len-4 and samples data_in at len-2.
  - data_out is NOT read-ahead; it changes only on a pop.
  - A pop while empty drives UNDERRUN_WORD, sets underflow, and leaves the pointers unchanged.
  - Pops are accepted in any state.
- flush:
  - Clears pointers and level.
  - Forces the state machine to IDLE with master_en = 0.
  - Does not clear overflow, underflow or frame_count.
  - A write in the same cycle as flush is dropped.
- FSM states:
  - IDLE: if tx_enable && reg_number != 0 && level >= reg_number, go to START. reg_number == 0 never starts.
  - START: master_en = 1 for exactly one cycle; word counter wcnt = 0; go to SEND.
  - SEND: each update increments wcnt. When wcnt reaches reg_number, go to GAP with gcnt = 0.
  - GAP: counts 2*reg_length + 4 cycles, covering the master's two trailing word periods plus margin. Then frame_count increments and the FSM returns to IDLE. A back-to-back frame may start on the next cycle.
- Width rule: reg_number and reg_length are sampled into registers on START and held for the frame; changes mid-frame are ignored.
- tx_enable deasserted mid-frame: the current frame completes; no new start.
- GAP counter is 9 bits: the maximum is 2*127 + 4 = 258.

Test Plan:
- Reset, write 4 words 0x11111111..0x44444444, reg_number = 4, reg_length = 32, tx_enable = 1 -> one-cycle master_en pulse; four updates yield data_out 0x11111111, 0x22222222, 0x33333333, 0x44444444, each 2 cycles after its strobe; frame_count = 1 after 68 GAP cycles; level = 0.
- reg_number = 5 with only 4 words stored -> master_en stays 0 and busy = 0; the 5th write triggers START on the following cycle.
- 6 updates issued with 4 words stored -> pops 5 and 6 drive 0x00000000; underflow = 1; level stays 0.
- Fill 512 words, then write once more -> full = 1, overflow = 1, level = 512, the 513th word is absent from the read sequence.
- Mid-SEND flush -> level = 0, state IDLE, master_en = 0; async reset pulse mid-GAP -> all outputs return to reset values immediately.
- 8 words stored, reg_number = 4 -> two frames back-to-back, the second master_en exactly 1 cycle after the first GAP ends; frame_count = 2.
